// File: rtl/mult_seq_ctrl_if.sv
// Handshake and adder bus for the sequential multiplier controller.
// slave  : the controller's view (accepts operands, drives the adder, presents the product)
// master : the environment's view (upstream source, adder, downstream sink)
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [2*WIDTH-1:0]   add_a;
  logic [2*WIDTH-1:0]   add_b;
  logic [2*WIDTH-1:0]   add_s;
  logic                 add_cout;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;

  modport slave (
    input  in_valid, in_a, in_b, add_s, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, out_p
  );

  modport master (
    output in_valid, in_a, in_b, add_s, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_p
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add controller for unsigned WIDTH x WIDTH multiplication.
// One partial product per cycle is presented to an external 2*WIDTH-bit adder;
// the adder's sum is registered back into the accumulator.
// Optional build macro: EARLY_TERM_EN -- finish as soon as the remaining
// multiplier bits are all zero instead of always running WIDTH iterations.
module mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_seq_ctrl_if.slave  bus
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_out_p;
  logic             w_accept;
  logic             w_last;
  logic             w_unused_cout;

  // The adder carry-out is never set for legal operands; it is observed only by the bench.
  assign w_unused_cout = bus.add_cout;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;

`ifdef EARLY_TERM_EN
  // Last iteration: counter exhausted, or no set multiplier bits remain after this shift.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || ((r_mplier >> 1) == '0);
`else
  // Last iteration: fixed WIDTH passes regardless of operand values.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_next = S_RUN;
      S_RUN:   if (w_last)        w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state; adder operands are zero outside RUN.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = '0;
    bus.add_b     = '0;
    case (r_state)
      S_IDLE: bus.in_ready = 1'b1;
      S_RUN: begin
        bus.add_a = r_acc;
        bus.add_b = r_mplier[0] ? r_mcand : '0;
      end
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_p = r_out_p;

  // Datapath: load operands on accept, then shift-and-accumulate once per RUN cycle.
  // NOTE: datapath registers are reset too, so an aborted product never leaks to out_p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out_p  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= PW'(bus.in_a);
            r_mplier <= bus.in_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= bus.add_s;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) r_out_p <= bus.add_s;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed operand pairs feed a
// scoreboard queue; an independent monitor compares each presented product.
// Honours EARLY_TERM_EN for the expected latencies.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic clk;
  logic rst_n;

  mult_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model of the downstream ripple adder.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] p;
    int            acc_edge;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   rise_q[$];
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic prev_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
`ifdef EARLY_TERM_EN
    int l;
    l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
    return l;
`else
    return WIDTH;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency at each rising out_valid, product while valid, pop on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_valid) begin
        rise_q.push_back(cyc);
        if (exp_q.size() > 0) check("latency", 32'(cyc - exp_q[0].acc_edge), 32'(exp_q[0].lat));
      end
      if (bus.out_valid) begin
        check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h with empty scoreboard", bus.out_p);
        end else begin
          check("out_p", 32'(bus.out_p), 32'(exp_q[0].p));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (!bus.in_ready) check("add_cout", 32'(bus.add_cout), 32'd0);
    end
    prev_valid <= bus.out_valid;
  end

  // Offer one operand pair and wait (bounded) for it to be accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: operands %0h x %0h never accepted", a, b);
    end else begin
      exp_q.push_back('{p: p, acc_edge: cyc + 1, lat: exp_lat(b)});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 8'h5A;
    bus.in_b     = 8'hC3;
  endtask

  // Wait (bounded) for the scoreboard to empty.
  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d products outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pb;
    logic [15:0] acc;
    int          n0;

    cyc          = 0;
    n_cmp        = 0;
    n_err        = 0;
    prev_valid   = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_p",     32'(bus.out_p),     32'd0);
    check("rst_add_a",     32'(bus.add_a),     32'd0);
    check("rst_add_b",     32'(bus.add_b),     32'd0);
    rst_n = 1'b1;

    // Basic product, in_ready low throughout RUN/DONE.
    send(8'd13, 8'd11, 16'h008F);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid) break;
    end
    drain();

    // Max operands with the partial-product sequence on the adder inputs.
    send(8'hFF, 8'hFF, 16'hFE01);
    pb  = 16'h00FF;
    acc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("max_add_b", 32'(bus.add_b), 32'(pb));
      check("max_add_a", 32'(bus.add_a), 32'(acc));
      acc = acc + pb;
      pb  = pb << 1;
    end
    drain();

    // Backpressure with a second request held pending until IDLE.
    bus.out_ready = 1'b0;
    fork
      begin
        send(8'h80, 8'h02, 16'h0100);
        send(8'h0C, 8'h0A, 16'h0078);
      end
      begin
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          check("bp_out_valid", 32'(bus.out_valid), 32'd1);
          check("bp_out_p",     32'(bus.out_p),     32'h0100);
          check("bp_in_ready",  32'(bus.in_ready),  32'd0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Zero operand followed back-to-back by a second pair.
    n0 = rise_q.size();
    send(8'h00, 8'hA5, 16'h0000);
    send(8'h07, 8'h09, 16'h003F);
    drain();
    if (rise_q.size() >= n0 + 2)
      check("b2b_period", 32'(rise_q[n0 + 1] - rise_q[n0]), 32'(exp_lat(8'h09) + 2));
    else begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_pulses: got %0d out_valid pulses, expected 2", rise_q.size() - n0);
    end

    // Asynchronous reset in the 4th RUN cycle aborts the product.
    send(8'hFF, 8'hFF, 16'hFE01);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_p",     32'(bus.out_p),     32'd0);
    check("abort_add_a",     32'(bus.add_a),     32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h03, 8'h05, 16'h000F);
    drain();

    // Zero multiplier, single top multiplier bit, and a zero multiplicand.
    send(8'h3C, 8'h00, 16'h0000);
    send(8'h01, 8'h80, 16'h0080);
    send(8'h00, 8'hFF, 16'h0000);
    send(8'hAB, 8'h01, 16'h00AB);
    drain();

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Sequential shift-and-add controller for unsigned WIDTH x WIDTH multiplication. It sits directly upstream of the combinational 2*WIDTH-bit ripple adder (16-bit for default WIDTH) and drives that adder's A/B operands one partial product per cycle. It registers the adder's sum back into an accumulator. Operands arrive and the product leaves through valid/ready handshakes, towards the TinyTapeout IO wrapper.

Parameters:
WIDTH, 8, operand width in bits; product, accumulator and adder width = 2*WIDTH
CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  WIDTH  multiplicand, unsigned
in_b  input  WIDTH  multiplier, unsigned
add_a  output  2*WIDTH  to adder A: current accumulator
add_b  output  2*WIDTH  to adder B: current partial product
add_s  input  2*WIDTH  from adder S: add_a + add_b
add_cout  input  1  from adder Cout; never set for valid operation
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
out_p  output  2*WIDTH  registered product

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_p=0.
  - acc=0, mcand=0, mplier=0, cnt=0.
  - add_a=0, add_b=0.
- Reset mid-operation aborts the calculation with no output and returns to IDLE.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE), purely from state.
- IDLE:
  - On in_valid && in_ready: mcand <= zero-extended in_a; mplier <= in_b; acc <= 0; cnt <= 0; go to RUN.
  - in_a/in_b are sampled only on this accept edge.
- RUN, each cycle:
  - add_a = acc.
  - add_b = mplier[0] ? mcand : 0.
  - On the edge: acc <= add_s; mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt+1.
  - When cnt==WIDTH-1 on the edge: out_p <= add_s; go to DONE.
- add_a/add_b are combinational from registered state. They are driven 0 outside RUN.
- DONE:
  - out_valid=1; out_p held stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid falls the next cycle.
- Latency: out_valid rises exactly WIDTH edges after the accept edge (8 for default).
- Back-to-back operation: one idle cycle between products, because in_ready is low during the DONE handshake cycle. Peak throughput is 1 product per WIDTH+2 cycles.
- in_valid during RUN or DONE is ignored; the upstream must hold its data.
- Arithmetic:
  - Unsigned only. Shifts are logical; the mcand shift cannot overflow within WIDTH iterations.
  - Product always fits in 2*WIDTH bits.
  - add_cout is ignored. A set add_cout indicates an adder fault (assertion in the bench only).
- Boundary cases:
  - in_a=0 or in_b=0 still takes the full WIDTH cycles and yields 0.
  - Max operands yield (2^WIDTH-1)^2 with no wrap.

Optional Feature:
EARLY_TERM_EN
- Defined: in RUN, if the post-shift multiplier (mplier>>1) is zero on an edge, the block finishes early. out_p <= add_s and it goes to DONE that same edge, regardless of cnt. Latency = max(1, index of highest set bit of in_b + 1) edges. in_b=0 completes in 1 edge with product 0.
- Undefined: fixed latency of WIDTH edges as above. The early-termination comparator is absent.

Test Plan:
- Basic product: in_a=8'd13, in_b=8'd11, out_ready=1 -> out_valid exactly 8 edges after accept; out_p=16'h008F; in_ready low throughout RUN/DONE.
- Max operands: in_a=8'hFF, in_b=8'hFF -> out_p=16'hFE01; add_cout never 1; add_b sequence 00FF,01FE,03FC,...,7F80.
- Backpressure and ignored input:
  - in_a=8'h80, in_b=8'h02 with out_ready=0 for 5 cycles -> out_p=16'h0100 held stable; out_valid stays 1.
  - A second in_valid during this time is not accepted until IDLE.
- Zero operand and back-to-back:
  - in_a=8'h00, in_b=8'hA5, then immediately in_a=8'h07, in_b=8'h09 -> products 16'h0000 then 16'h003F.
  - Exactly one idle cycle between out_valid pulses when out_ready=1.
- Reset mid-operation: rst_n low asynchronously at the 4th RUN cycle of 8'hFF x 8'hFF -> out_valid=0, in_ready=1, out_p=0 immediately. A following 8'h03 x 8'h05 yields 16'h000F.
- EARLY_TERM_EN defined: in_a=8'h03, in_b=8'h05 -> out_p=16'h000F after 3 edges. in_b=8'h00 -> product 0 after 1 edge. in_b=8'h80 -> still 8 edges.
